lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Parametrised load/store unit between the core pipeline and the data-memory port.
- Accepts one load/store request at a time and runs a req/gnt/rvalid handshake to memory.
- Generates byte strobes, lane-shifts write data, and aligns plus sign/zero-extends read data.
- Reports misalignment, illegal size and memory timeout as a single error response; successor to the fixed 32-bit, zero-wait dmem port.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- MAX_WAIT, 255, cycles allowed in REQ or WAIT before a timeout error; counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock; the block's only clock.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit idle; the request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend the load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  error qualifier, valid with resp_valid.
- dmem_req  out  1  memory request.
- dmem_gnt  in  1  memory accepted the request.
- dmem_rvalid  in  1  memory completed the access (read data valid / write done).
- dmem_addr  out  ADDR_W  XLEN/8-aligned address.
- dmem_we  out  1  write enable.
- dmem_wstrb  out  XLEN/8  byte-lane write mask; all zeros on reads.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_rdata  in  XLEN  read data.

Behaviour:
- Reset values: req_ready=1; all other outputs 0; FSM in IDLE; wait counter 0.
- Reset mid-transaction abandons the access. A dmem_rvalid that arrives while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP. REQ2 and WAIT2 exist only with the optional feature.
- IDLE:
  - req_ready=1. On accept, latch the request.
  - Illegal request goes straight to RESP with err=1. Illegal means size=3 when XLEN=32, or misaligned (addr mod 2^size != 0).
  - Otherwise go to REQ.
- REQ:
  - dmem_req=1 and all dmem_* outputs are held stable.
  - On dmem_gnt go to WAIT. dmem_gnt and dmem_rvalid in the same cycle go directly to RESP.
- WAIT: on dmem_rvalid, capture dmem_rdata and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in this cycle.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ/WAIT. On reaching MAX_WAIT go to RESP with err=1 and drop dmem_req.
- Latency: minimum accept-to-resp_valid is 3 cycles (gnt in the first REQ cycle, rvalid one cycle later). Throughput is one access at a time.
- Lane arithmetic:
  - off = addr[clog2(XLEN/8)-1:0].
  - dmem_addr = addr with off bits cleared.
  - dmem_wstrb = ((1<<(1<<size))-1) << off.
  - dmem_wdata = req_wdata << (8*off).
  - Load: (dmem_rdata >> 8*off), truncated to 8<<size bits, then sign-extended unless req_unsigned. Size = XLEN ignores req_unsigned.
- resp_rdata is 0 for stores and for err=1.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without the macro, any misaligned address returns err=1 after one RESP cycle and makes no dmem access.
- With the macro defined, misaligned accesses are supported:
  - Misaligned but inside one XLEN word: issued as a single access with shifted strobes.
  - Crossing a word boundary: first access at the aligned addr covering the upper lanes; REQ2/WAIT2 then access dmem_addr+XLEN/8 covering the remaining low lanes.
  - Read halves are concatenated before extension.
  - An error or timeout in either part gives err=1. There is no rollback of a completed first store part.
  - Minimum latency for a split access is 5 cycles.
  - Illegal size is still an error.

Test Plan:
- XLEN=32, signed byte load at addr 0x103 with dmem_rdata=0x80_00_00_00, gnt immediate, rvalid next cycle -> dmem_addr=0x100, wstrb=0, resp_valid in cycle 3, resp_rdata=0xFFFFFF80, err=0.
- Half store at 0x202, wdata=0x0000BEEF -> dmem_we=1, wstrb=0b1100, dmem_wdata=0xBEEF0000, resp_rdata=0.
- Word load at 0x101, macro off -> no dmem_req; resp_valid one cycle later with err=1.
- Same load with macro on, memory words 0x100=0x44332211 and 0x104=0x88776655 -> two requests (0x100, then 0x104); resp_rdata=0x55443322.
- dmem_gnt held low with MAX_WAIT=4 -> dmem_req deasserts and resp_err=1 at count 4; a later stray dmem_rvalid in IDLE causes no response.
- Assert rst while in WAIT -> all outputs return to reset values immediately; req_ready=1 on the first clock after rst falls.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit on a req/gnt/rvalid memory port.
// Define LSU_MISALIGN_SPLIT_EN to serve misaligned accesses (word-crossing ones in two beats).
module lsu_ctrl #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              dmem_req,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, REQ2, WAIT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

    state_t            state, state_d, after_lo;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              l_we, l_uns;
    logic [1:0]        l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [XLEN-1:0]   l_wdata;
    logic [XLEN-1:0]   rd_lo, lo_d;
    logic              err_q, err_d;

    logic              accept, illegal, bad_size, timeout;
    logic [3:0]        in_bytes, l_bytes;
    logic [OFF_W-1:0]  off;
    logic [OFF_W+2:0]  sh;
    logic [ADDR_W-1:0] base;
    logic [NB-1:0]     strb_lo;
    logic [XLEN-1:0]   wd_lo;
    logic [XLEN-1:0]   rd_shift, mask, ext;
    logic              sgn;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              l_cross, cross;
    logic [XLEN-1:0]   rd_hi, hi_d;
    logic [2*NB-1:0]   strb_full;
    logic [2*XLEN-1:0] wd_full;
    logic [NB-1:0]     strb_hi;
    logic [XLEN-1:0]   wd_hi;
`endif

    assign accept   = req_valid && (state == IDLE);
    assign in_bytes = 4'd1 << req_size;
    assign bad_size = (XLEN == 32) && (req_size == 2'd3);
    assign timeout  = cnt >= CNT_W'(MAX_WAIT - 1);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign cross    = (int'(req_addr[OFF_W-1:0]) + int'(in_bytes)) > NB;
    assign illegal  = bad_size;
    assign after_lo = l_cross ? REQ2 : RESP;
`else
    assign illegal  = bad_size ||
                      ((req_addr[2:0] & 3'(in_bytes - 4'd1)) != 3'd0);
    assign after_lo = RESP;
`endif

    // Lane arithmetic on the latched request
    assign off     = l_addr[OFF_W-1:0];
    assign sh      = {off, 3'b000};
    assign base    = {l_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign l_bytes = 4'd1 << l_size;

`ifdef LSU_MISALIGN_SPLIT_EN
    assign strb_full = ((2*NB)'(1) << l_bytes) - (2*NB)'(1);
    assign strb_lo   = strb_full[NB-1:0] << off;
    assign strb_hi   = NB'((strb_full << off) >> NB);
    assign wd_full   = {XLEN'(0), l_wdata} << sh;
    assign wd_lo     = wd_full[XLEN-1:0];
    assign wd_hi     = wd_full[2*XLEN-1:XLEN];
    assign rd_shift  = XLEN'({rd_hi, rd_lo} >> sh);
`else
    assign strb_lo  = ((NB'(1) << l_bytes) - NB'(1)) << off;
    assign wd_lo    = l_wdata << sh;
    assign rd_shift = rd_lo >> sh;
`endif

    always_comb begin
        mask = '1;
        sgn  = 1'b0;
        unique case (l_size)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sgn  = rd_shift[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sgn  = rd_shift[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sgn  = rd_shift[31];
            end
            default: begin
                mask = '1;
                sgn  = 1'b0;
            end
        endcase
        ext = (rd_shift & mask) | ((sgn && !l_uns) ? ~mask : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            rd_lo   <= '0;
            l_we    <= 1'b0;
            l_uns   <= 1'b0;
            l_size  <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err_q <= err_d;
            rd_lo <= lo_d;
            if (accept) begin
                l_we    <= req_we;
                l_uns   <= req_unsigned;
                l_size  <= req_size;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
            end
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_cross <= 1'b0;
            rd_hi   <= '0;
        end else begin
            rd_hi <= hi_d;
            if (accept) begin
                l_cross <= cross;
            end
        end
    end
`endif

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        err_d   = err_q;
        lo_d    = rd_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
        hi_d    = rd_hi;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    err_d   = illegal;
                    state_d = illegal ? RESP : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt + CNT_W'(1);
                if (dmem_gnt && dmem_rvalid) begin
                    lo_d    = dmem_rdata;
                    state_d = after_lo;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                if (dmem_rvalid) begin
                    lo_d    = dmem_rdata;
                    state_d = after_lo;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ2: begin
                cnt_d = cnt + CNT_W'(1);
                if (dmem_gnt && dmem_rvalid) begin
                    hi_d    = dmem_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (dmem_gnt) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                cnt_d = cnt + CNT_W'(1);
                if (dmem_rvalid) begin
                    hi_d    = dmem_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        // Second beat gets its own full timeout budget
        if (state_d == REQ2 && state != REQ2) begin
            cnt_d = '0;
        end
`endif
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !l_we) ? ext : '0;
        dmem_req   = 1'b0;
        dmem_addr  = '0;
        dmem_we    = 1'b0;
        dmem_wstrb = '0;
        dmem_wdata = '0;
        if (state == REQ) begin
            dmem_req   = 1'b1;
            dmem_addr  = base;
            dmem_we    = l_we;
            dmem_wstrb = l_we ? strb_lo : '0;
            dmem_wdata = wd_lo;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state == REQ2) begin
            dmem_req   = 1'b1;
            dmem_addr  = base + ADDR_W'(NB);
            dmem_we    = l_we;
            dmem_wstrb = l_we ? strb_hi : '0;
            dmem_wdata = wd_hi;
        end
`endif
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus hand sequences for lsu_ctrl (XLEN=32, MAX_WAIT=4).
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_req, dmem_gnt, dmem_rvalid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          n;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] erdata;
        logic        eerr;
        int          elat;
    } vec_t;

    localparam int NV = 13;
    vec_t        v [NV];
    logic [31:0] mem [256];
    logic        gnt_en;
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_strb [2];
    logic        r_we [2];
    int          ntests = 0;
    int          nfail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int nreq, output int lat,
                           output logic err, output logic [31:0] rdata);
        int         ng;
        logic       pend;
        logic [7:0] raddr;
        nreq = 0; lat = -1; err = 1'b0; rdata = '0;
        ng = 0; pend = 1'b0; raddr = '0;
        for (int k = 0; k < 2; k++) begin
            r_addr[k] = '0; r_wdata[k] = '0; r_strb[k] = '0; r_we[k] = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (pend) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem[raddr];
                pend = 1'b0;
            end
            if (dmem_req) begin
                nreq++;
                if (gnt_en) begin
                    if (ng < 2) begin
                        r_addr[ng] = dmem_addr; r_wdata[ng] = dmem_wdata;
                        r_strb[ng] = dmem_wstrb; r_we[ng] = dmem_we;
                    end
                    ng++;
                    dmem_gnt = 1'b1;
                    pend = 1'b1;
                    raddr = dmem_addr[9:2];
                end
            end
            if (resp_valid) begin
                lat = c; err = resp_err; rdata = resp_rdata;
                break;
            end
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        int          nreq, lat, pulses;
        logic        err;
        logic [31:0] rdata;
        int          s_n, s_lat;
        logic        s_err;
        logic [31:0] s_rd, s_a1, s_w0, s_w1;
        logic [3:0]  s_s0, s_s1;

        v[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8000_0000,
                  1, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 3};
        v[1]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 32'h0,
                  1, 32'h200, 4'hC, 32'hBEEF_0000, 32'h0, 1'b0, 3};
        v[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8000_0000,
                  1, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 1'b0, 3};
        v[3]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8000_1234,
                  1, 32'h100, 4'h0, 32'h0, 32'hFFFF_8000, 1'b0, 3};
        v[4]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8000_1234,
                  1, 32'h100, 4'h0, 32'h0, 32'h0000_8000, 1'b0, 3};
        v[5]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h8000_1234,
                  1, 32'h100, 4'h0, 32'h0, 32'h0000_1234, 1'b0, 3};
        v[6]  = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h8877_6655,
                  1, 32'h104, 4'h0, 32'h0, 32'h8877_6655, 1'b0, 3};
        v[7]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 32'h0,
                  1, 32'h100, 4'h2, 32'h0000_AB00, 32'h0, 1'b0, 3};
        v[8]  = '{1'b1, 2'd2, 1'b0, 32'h208, 32'hDEAD_BEEF, 32'h0,
                  1, 32'h208, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 3};
        v[9]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0000_7F00,
                  1, 32'h100, 4'h0, 32'h0, 32'h0000_007F, 1'b0, 3};
        v[10] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0,
                  0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
`ifdef LSU_MISALIGN_SPLIT_EN
        v[11] = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h4433_2211,
                  1, 32'h100, 4'h0, 32'h0, 32'h0000_3322, 1'b0, 3};
        v[12] = '{1'b1, 2'd1, 1'b0, 32'h201, 32'h0000_BEEF, 32'h0,
                  1, 32'h200, 4'h6, 32'h00BE_EF00, 32'h0, 1'b0, 3};
`else
        v[11] = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h4433_2211,
                  0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        v[12] = '{1'b1, 2'd1, 1'b0, 32'h201, 32'h0000_BEEF, 32'h0,
                  0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
`endif

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; gnt_en = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {req_ready, resp_valid, resp_err, dmem_req, dmem_we, dmem_wstrb,
             dmem_addr != 0, dmem_wdata != 0, resp_rdata != 0},
            {1'b1, 11'b0});
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            mem[v[i].addr[9:2]] = v[i].rd;
            run_req(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata,
                    nreq, lat, err, rdata);
            chk($sformatf("v%0d_nreq", i), 64'(nreq), 64'(v[i].n));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].elat));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(v[i].eerr));
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(v[i].erdata));
            if (v[i].n > 0) begin
                chk($sformatf("v%0d_addr", i), 64'(r_addr[0]), 64'(v[i].eaddr));
                chk($sformatf("v%0d_we", i), 64'(r_we[0]), 64'(v[i].we));
                chk($sformatf("v%0d_strb", i), 64'(r_strb[0]), 64'(v[i].estrb));
                if (v[i].we) begin
                    chk($sformatf("v%0d_wdata", i), 64'(r_wdata[0]), 64'(v[i].ewdata));
                end
            end
        end

        // Word load crossing a word boundary
        mem[8'h40] = 32'h4433_2211;
        mem[8'h41] = 32'h8877_6655;
`ifdef LSU_MISALIGN_SPLIT_EN
        s_n = 2; s_lat = 5; s_err = 1'b0; s_rd = 32'h5544_3322; s_a1 = 32'h104;
`else
        s_n = 0; s_lat = 1; s_err = 1'b1; s_rd = 32'h0; s_a1 = 32'h0;
`endif
        run_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, nreq, lat, err, rdata);
        chk("split_ld_nreq", 64'(nreq), 64'(s_n));
        chk("split_ld_lat", 64'(lat), 64'(s_lat));
        chk("split_ld_err", 64'(err), 64'(s_err));
        chk("split_ld_rdata", 64'(rdata), 64'(s_rd));
        chk("split_ld_addr1", 64'(r_addr[1]), 64'(s_a1));

        // Half store crossing a word boundary
`ifdef LSU_MISALIGN_SPLIT_EN
        s_n = 2; s_err = 1'b0; s_s0 = 4'h8; s_s1 = 4'h1;
        s_w0 = 32'hEF00_0000; s_w1 = 32'h0000_00BE;
`else
        s_n = 0; s_err = 1'b1; s_s0 = 4'h0; s_s1 = 4'h0;
        s_w0 = 32'h0; s_w1 = 32'h0;
`endif
        run_req(1'b1, 2'd1, 1'b0, 32'h203, 32'h0000_BEEF, nreq, lat, err, rdata);
        chk("split_st_nreq", 64'(nreq), 64'(s_n));
        chk("split_st_err", 64'(err), 64'(s_err));
        chk("split_st_strb", 64'({r_strb[0], r_strb[1]}), 64'({s_s0, s_s1}));
        chk("split_st_wdata", {r_wdata[0], r_wdata[1]}, {s_w0, s_w1});

        // Timeout with gnt held low, then a stray rvalid in IDLE
        gnt_en = 1'b0;
        run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, nreq, lat, err, rdata);
        gnt_en = 1'b1;
        chk("tmo_req_cycles", 64'(nreq), 64'd4);
        chk("tmo_lat", 64'(lat), 64'd5);
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_rdata", 64'(rdata), 64'd0);
        pulses = 0;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (resp_valid || dmem_req) pulses++;
        end
        chk("stray_rvalid", 64'(pulses), 64'd0);
        chk("stray_ready", 64'(req_ready), 64'd1);

        // Reset while waiting for rvalid
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h300; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_req", 64'({dmem_req, dmem_we, dmem_wstrb}), 64'(6'b11_1111));
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("mid_wait", 64'({req_ready, dmem_req, resp_valid}), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs",
            {req_ready, resp_valid, resp_err, dmem_req, dmem_we, dmem_wstrb,
             dmem_addr != 0, dmem_wdata != 0, resp_rdata != 0},
            {1'b1, 11'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_ready", 64'(req_ready), 64'd1);

        mem[8'h40] = 32'h8000_0000;
        run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, nreq, lat, err, rdata);
        chk("post_rst_lat", 64'(lat), 64'd3);
        chk("post_rst_rdata", 64'(rdata), 64'hFFFF_FF80);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
